// File: rtl/voice_allocator_pkg.sv
// Shared constants for the voice allocator slice.
//   NBANKS_DEF / SLOT_W_DEF : default voice count and slot-index width
//   MIDI_IDLE               : table value marking an unused voice
//   ST_*                    : event FSM state encoding
package voice_allocator_pkg;

  localparam int unsigned NBANKS_DEF = 10;
  localparam int unsigned SLOT_W_DEF = 4;

  localparam logic [6:0] MIDI_IDLE = 7'h00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event channel into the voice allocator (valid/ready handshake).
//   i_valid : event valid (master -> slave)
//   i_note  : MIDI note number of the event
//   i_on    : 1 = note-on, 0 = note-off
//   o_ready : allocator can accept an event (slave -> master)
interface voice_allocator_if;

  logic       i_valid;
  logic       o_ready;
  logic [6:0] i_note;
  logic       i_on;

  modport master (output i_valid, output i_note, output i_on, input  o_ready);
  modport slave  (input  i_valid, input  i_note, input  i_on, output o_ready);

endinterface

// File: rtl/voice_allocator_slot_sequencer.sv
// Wrapping time-slot counter shared with the phase bank for alignment.
//   clk, rst    : clock, synchronous active-high reset
//   clk_en_i    : sample-rate enable; counter advances only when high
//   slot_o      : current slot index (resets to NBANKS-1)
//   slot_next_o : slot index that will be loaded on the next enabled edge
module slot_sequencer #(
  parameter int unsigned NBANKS = 10,
  parameter int unsigned SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic [SLOT_W-1:0] slot_next_o
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NBANKS - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = (slot_q == LAST) ? '0 : slot_q + SLOT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= LAST;
    end else if (clk_en_i) begin
      slot_q <= slot_d;
    end
  end

  assign slot_o      = slot_q;
  assign slot_next_o = slot_d;

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: accepts note events and keeps an NBANKS-entry voice table,
// emitting one voice's MIDI note per enabled cycle for the phase bank.
//   clk, rst : clock, synchronous active-high reset (overrides clk_en)
//   clk_en   : sample-rate enable; advances the slot stream only
//   ev       : note event channel (i_valid/o_ready/i_note/i_on)
//   o_midi   : note for the current slot (7'h00 = idle)
//   o_slot   : voice index of o_midi
//   o_full   : no idle voice in the table
//   o_voices : count of non-idle voices
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NBANKS = NBANKS_DEF,
  parameter int unsigned SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  voice_allocator_if.slave  ev,
  output logic [6:0]        o_midi,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_full,
  output logic [SLOT_W-1:0] o_voices
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NBANKS - 1);

  logic [6:0]        table_q [NBANKS];
  logic [6:0]        table_d [NBANKS];
  logic [1:0]        state_q, state_d;
  logic [6:0]        note_q, note_d;
  logic              on_q, on_d;
  logic [SLOT_W-1:0] idx_q, idx_d;
  logic              match_hit_q, match_hit_d;
  logic [SLOT_W-1:0] match_idx_q, match_idx_d;
  logic              free_hit_q, free_hit_d;
  logic [SLOT_W-1:0] free_idx_q, free_idx_d;
  logic [SLOT_W-1:0] steal_q, steal_d;
  logic [6:0]        midi_q;
  logic              full_q, full_d;
  logic [SLOT_W-1:0] voices_q, voices_d;
  logic [SLOT_W-1:0] slot_next;

  slot_sequencer #(
    .NBANKS (NBANKS),
    .SLOT_W (SLOT_W)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .clk_en_i    (clk_en),
    .slot_o      (o_slot),
    .slot_next_o (slot_next)
  );

  assign ev.o_ready = (state_q == ST_IDLE);

  // Event FSM: scan the whole table serially, then apply one write.
  always_comb begin
    table_d     = table_q;
    state_d     = state_q;
    note_d      = note_q;
    on_d        = on_q;
    idx_d       = idx_q;
    match_hit_d = match_hit_q;
    match_idx_d = match_idx_q;
    free_hit_d  = free_hit_q;
    free_idx_d  = free_idx_q;
    steal_d     = steal_q;
    case (state_q)
      ST_IDLE: begin
        // Events carrying note 0 are accepted but never enter the table.
        if (ev.i_valid && ev.i_note != MIDI_IDLE) begin
          note_d      = ev.i_note;
          on_d        = ev.i_on;
          match_hit_d = 1'b0;
          free_hit_d  = 1'b0;
          idx_d       = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!match_hit_q && table_q[idx_q] == note_q) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!free_hit_q && table_q[idx_q] == MIDI_IDLE) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (idx_q == LAST) begin
          state_d = ST_APPLY;
        end else begin
          idx_d = idx_q + SLOT_W'(1);
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        if (on_q) begin
          if (!match_hit_q) begin
            if (free_hit_q) begin
              table_d[free_idx_q] = note_q;
            end else begin
              table_d[steal_q] = note_q;
              steal_d = (steal_q == LAST) ? '0 : steal_q + SLOT_W'(1);
            end
          end
        end else if (match_hit_q) begin
          table_d[match_idx_q] = MIDI_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy is derived from the registered table, so it trails APPLY by one cycle.
  always_comb begin
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < NBANKS; i++) begin
      if (table_q[i] != MIDI_IDLE) cnt = cnt + 1;
    end
    voices_d = SLOT_W'(cnt);
    full_d   = (cnt == NBANKS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NBANKS; i++) table_q[i] <= MIDI_IDLE;
      state_q     <= ST_IDLE;
      note_q      <= MIDI_IDLE;
      on_q        <= 1'b0;
      idx_q       <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
      steal_q     <= '0;
      midi_q      <= MIDI_IDLE;
      full_q      <= 1'b0;
      voices_q    <= '0;
    end else begin
      table_q     <= table_d;
      state_q     <= state_d;
      note_q      <= note_d;
      on_q        <= on_d;
      idx_q       <= idx_d;
      match_hit_q <= match_hit_d;
      match_idx_q <= match_idx_d;
      free_hit_q  <= free_hit_d;
      free_idx_q  <= free_idx_d;
      steal_q     <= steal_d;
      full_q      <= full_d;
      voices_q    <= voices_d;
      // Reads the pre-write table: a same-edge write shows up next rotation.
      if (clk_en) midi_q <= table_q[slot_next];
    end
  end

  assign o_midi   = midi_q;
  assign o_full   = full_q;
  assign o_voices = voices_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator.
module tb_voice_allocator;

  localparam int unsigned NB = 10;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [6:0]    o_midi;
  logic [SW-1:0] o_slot;
  logic          o_full;
  logic [SW-1:0] o_voices;

  voice_allocator_if ev ();

  voice_allocator #(
    .NBANKS (NB),
    .SLOT_W (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .ev       (ev),
    .o_midi   (o_midi),
    .o_slot   (o_slot),
    .o_full   (o_full),
    .o_voices (o_voices)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [6:0] cap [NB];
  logic [6:0] exp_t [NB];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two full rotations of the slot stream; records the last note seen per slot.
  task automatic capture();
    for (int i = 0; i < NB; i++) cap[i] = 7'h7f;
    for (int i = 0; i < 2 * NB; i++) begin
      tick();
      if (o_slot < SW'(NB)) cap[o_slot] = o_midi;
    end
  endtask

  task automatic send(input logic [6:0] n, input logic on);
    int t;
    t = 0;
    while (!ev.o_ready && t < 50) begin
      tick();
      t++;
    end
    if (!ev.o_ready) begin
      vectors++;
      errors++;
      $display("FAIL send_wait_ready: o_ready=%0b required 1", ev.o_ready);
    end
    ev.i_valid = 1'b1;
    ev.i_note  = n;
    ev.i_on    = on;
    tick();
    ev.i_valid = 1'b0;
  endtask

  // Counts samples with o_ready low, starting right after the accepting edge.
  task automatic wait_idle(output int lowcnt);
    lowcnt = 0;
    while (!ev.o_ready && lowcnt < 50) begin
      lowcnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_en = 1'b1;
    tick();
    tick();
    vectors++; if (o_slot !== 4'd9) begin errors++; $display("FAIL reset_slot: got %0d required 9", o_slot); end
    vectors++; if (o_midi !== 7'h00) begin errors++; $display("FAIL reset_midi: got %h required 00", o_midi); end
    vectors++; if (ev.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ev.o_ready); end
    vectors++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", o_full); end
    vectors++; if (o_voices !== 4'd0) begin errors++; $display("FAIL reset_voices: got %0d required 0", o_voices); end
    rst = 1'b0;
    for (int i = 0; i < NB; i++) begin
      tick();
      vectors++; if (o_slot !== SW'(i)) begin errors++; $display("FAIL slot_seq: got %0d required %0d", o_slot, i); end
      vectors++; if (o_midi !== 7'h00) begin errors++; $display("FAIL idle_midi: got %h required 00", o_midi); end
    end
    tick();
    vectors++; if (o_slot !== 4'd0) begin errors++; $display("FAIL slot_wrap: got %0d required 0", o_slot); end
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (o_slot !== 4'd0) begin errors++; $display("FAIL slot_hold: got %0d required 0", o_slot); end
    end
    clk_en = 1'b1;
    vectors++; if (o_voices !== 4'd0) begin errors++; $display("FAIL idle_voices: got %0d required 0", o_voices); end
  endtask

  task automatic test_note_on();
    int lc;
    send(7'h45, 1'b1);
    wait_idle(lc);
    vectors++; if (lc !== 11) begin errors++; $display("FAIL on_busy_cycles: got %0d required 11", lc); end
    tick();
    vectors++; if (o_voices !== 4'd1) begin errors++; $display("FAIL on_voices: got %0d required 1", o_voices); end
    vectors++; if (o_full !== 1'b0) begin errors++; $display("FAIL on_full: got %b required 0", o_full); end
    capture();
    for (int i = 0; i < NB; i++) begin
      exp_t[i] = (i == 0) ? 7'h45 : 7'h00;
      vectors++; if (cap[i] !== exp_t[i]) begin errors++; $display("FAIL on_table[%0d]: got %h required %h", i, cap[i], exp_t[i]); end
    end
  endtask

  task automatic test_retrigger();
    int lc;
    send(7'h45, 1'b1);
    wait_idle(lc);
    tick();
    vectors++; if (o_voices !== 4'd1) begin errors++; $display("FAIL retrig_voices: got %0d required 1", o_voices); end
    capture();
    vectors++; if (cap[0] !== 7'h45) begin errors++; $display("FAIL retrig_slot0: got %h required 45", cap[0]); end
    vectors++; if (cap[1] !== 7'h00) begin errors++; $display("FAIL retrig_slot1: got %h required 00", cap[1]); end
    send(7'h45, 1'b0);
    wait_idle(lc);
    tick();
    vectors++; if (o_voices !== 4'd0) begin errors++; $display("FAIL off_voices: got %0d required 0", o_voices); end
    capture();
    vectors++; if (cap[0] !== 7'h00) begin errors++; $display("FAIL off_slot0: got %h required 00", cap[0]); end
  endtask

  task automatic test_steal();
    int lc;
    for (int k = 0; k < NB; k++) begin
      send(7'h30 + 7'(k), 1'b1);
      wait_idle(lc);
      tick();
      if (k == NB - 2) begin
        vectors++; if (o_full !== 1'b0) begin errors++; $display("FAIL nine_full: got %b required 0", o_full); end
        vectors++; if (o_voices !== 4'd9) begin errors++; $display("FAIL nine_voices: got %0d required 9", o_voices); end
      end
    end
    vectors++; if (o_full !== 1'b1) begin errors++; $display("FAIL ten_full: got %b required 1", o_full); end
    vectors++; if (o_voices !== 4'd10) begin errors++; $display("FAIL ten_voices: got %0d required 10", o_voices); end
    send(7'h3a, 1'b1);
    wait_idle(lc);
    tick();
    for (int i = 0; i < NB; i++) exp_t[i] = 7'h30 + 7'(i);
    exp_t[0] = 7'h3a;
    capture();
    for (int i = 0; i < NB; i++) begin
      vectors++; if (cap[i] !== exp_t[i]) begin errors++; $display("FAIL steal_table[%0d]: got %h required %h", i, cap[i], exp_t[i]); end
    end
    vectors++; if (o_voices !== 4'd10) begin errors++; $display("FAIL steal_voices: got %0d required 10", o_voices); end
    vectors++; if (o_full !== 1'b1) begin errors++; $display("FAIL steal_full: got %b required 1", o_full); end
    // Next steal must land on slot 1, showing the pointer moved past 0.
    send(7'h3b, 1'b1);
    wait_idle(lc);
    exp_t[1] = 7'h3b;
    capture();
    vectors++; if (cap[1] !== 7'h3b) begin errors++; $display("FAIL steal_ptr_slot1: got %h required 3b", cap[1]); end
    vectors++; if (cap[0] !== 7'h3a) begin errors++; $display("FAIL steal_ptr_slot0: got %h required 3a", cap[0]); end
  endtask

  task automatic test_noop();
    int lc;
    send(7'h50, 1'b0);
    wait_idle(lc);
    vectors++; if (lc !== 11) begin errors++; $display("FAIL miss_busy_cycles: got %0d required 11", lc); end
    capture();
    for (int i = 0; i < NB; i++) begin
      vectors++; if (cap[i] !== exp_t[i]) begin errors++; $display("FAIL miss_table[%0d]: got %h required %h", i, cap[i], exp_t[i]); end
    end
    send(7'h00, 1'b1);
    vectors++; if (ev.o_ready !== 1'b1) begin errors++; $display("FAIL zero_note_ready: got %b required 1", ev.o_ready); end
    tick();
    vectors++; if (ev.o_ready !== 1'b1) begin errors++; $display("FAIL zero_note_ready2: got %b required 1", ev.o_ready); end
    capture();
    for (int i = 0; i < NB; i++) begin
      vectors++; if (cap[i] !== exp_t[i]) begin errors++; $display("FAIL zero_table[%0d]: got %h required %h", i, cap[i], exp_t[i]); end
    end
    vectors++; if (o_voices !== 4'd10) begin errors++; $display("FAIL zero_voices: got %0d required 10", o_voices); end
  endtask

  task automatic test_reset_mid_scan();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(7'h40, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (ev.o_ready !== 1'b0) begin errors++; $display("FAIL scan_busy: got %b required 0", ev.o_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (ev.o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", ev.o_ready); end
    vectors++; if (o_slot !== 4'd9) begin errors++; $display("FAIL abort_slot: got %0d required 9", o_slot); end
    vectors++; if (o_midi !== 7'h00) begin errors++; $display("FAIL abort_midi: got %h required 00", o_midi); end
    for (int i = 0; i < 15; i++) tick();
    vectors++; if (ev.o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_late: got %b required 1", ev.o_ready); end
    vectors++; if (o_voices !== 4'd0) begin errors++; $display("FAIL abort_voices: got %0d required 0", o_voices); end
    capture();
    for (int i = 0; i < NB; i++) begin
      vectors++; if (cap[i] !== 7'h00) begin errors++; $display("FAIL abort_table[%0d]: got %h required 00", i, cap[i]); end
    end
  endtask

  initial begin
    ev.i_valid = 1'b0;
    ev.i_note  = 7'h00;
    ev.i_on    = 1'b0;
    rst        = 1'b1;
    clk_en     = 1'b1;
    test_reset();
    test_note_on();
    test_retrigger();
    test_steal();
    test_noop();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
